// File: rtl/slave_serial_port.sv
// slave_serial_port: host-facing serial front end of the slave.
// Deserializes rw/addr/data frames, strobes node writes, and
// shifts node reads back out on sdo. Optional parity bit per
// frame when SLAVE_PORT_PARITY_EN is defined.
// Ports: clk, reset (async, active high), cs_n/sclk/sdi (async
// pins), sdo, write/write_addr/write_node (memory write port),
// read_addr/read_node (memory read port), frame_err, busy.
module slave_serial_port #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_n,
    input  logic              sclk,
    input  logic              sdi,
    output logic              sdo,
    output logic              write,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_node,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] read_node,
    output logic              frame_err,
    output logic              busy
);

`ifdef SLAVE_PORT_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int SH_W  = DATA_W - 1 + PAR;
    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(DATA_W - 1 + PAR);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(DATA_W - 1);
`ifdef SLAVE_PORT_PARITY_EN
    localparam logic [CNT_W-1:0] CMD_RD   = CNT_W'(ADDR_W + 1);
`endif

    typedef enum logic [2:0] {
        IDLE, CMD, WDATA, RWAIT, RDATA, DONE
    } state_t;

    state_t state;

    // Synchronizers reset low so a cs_n already low at reset
    // release never looks like a falling edge.
    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, sdi_sync;
    logic cs_q, sclk_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync   <= '0;
            sclk_sync <= '0;
            sdi_sync  <= '0;
            cs_q      <= 1'b0;
            sclk_q    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            cs_q      <= cs_sync[SYNC_STAGES-1];
            sclk_q    <= sclk_sync[SYNC_STAGES-1];
        end
    end

    logic cs_s, sclk_s, sdi_s;
    logic cs_rise, cs_fall, sclk_rise, sclk_fall;

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    assign cs_rise   = cs_s & ~cs_q;
    assign cs_fall   = ~cs_s & cs_q;
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;

    logic [CNT_W-1:0]  cnt;
    logic [SH_W-1:0]   sh;
    logic [SH_W:0]     sh_next;
    logic [DATA_W-2:0] tx_sh;
    logic [ADDR_W-1:0] addr_q;

    assign sh_next = {sh, sdi_s};
    assign busy    = (state != IDLE);

`ifdef SLAVE_PORT_PARITY_EN
    // Running XOR of every received bit; nonzero means bad parity.
    logic par_acc, rd_bad, par_bad;
    assign par_bad = par_acc ^ sh_next[0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sh         <= '0;
            tx_sh      <= '0;
            addr_q     <= '0;
            sdo        <= 1'b0;
            write      <= 1'b0;
            write_addr <= '0;
            write_node <= '0;
            read_addr  <= '0;
            frame_err  <= 1'b0;
`ifdef SLAVE_PORT_PARITY_EN
            par_acc    <= 1'b0;
            rd_bad     <= 1'b0;
`endif
        end else begin
            write     <= 1'b0;
            frame_err <= 1'b0;
            if (cs_rise && state != IDLE && state != DONE) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                sdo       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state <= CMD;
                            cnt   <= '0;
                            sh    <= '0;
`ifdef SLAVE_PORT_PARITY_EN
                            par_acc <= 1'b0;
`endif
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            sh  <= sh_next[SH_W-1:0];
                            cnt <= cnt + 1'b1;
`ifdef SLAVE_PORT_PARITY_EN
                            par_acc <= par_bad;
`endif
                            if (cnt == CMD_LAST) begin
                                addr_q <= sh_next[ADDR_W-1:0];
                                if (sh_next[ADDR_W]) begin
                                    state <= WDATA;
                                    cnt   <= '0;
                                end else begin
`ifndef SLAVE_PORT_PARITY_EN
                                    read_addr <= sh_next[ADDR_W-1:0];
                                    state     <= RWAIT;
                                    cnt       <= '0;
`endif
                                end
                            end
`ifdef SLAVE_PORT_PARITY_EN
                            // Reads carry their parity bit right after addr.
                            else if (cnt == CMD_RD) begin
                                rd_bad    <= par_bad;
                                frame_err <= par_bad;
                                if (!par_bad)
                                    read_addr <= sh_next[ADDR_W:1];
                                state <= RWAIT;
                                cnt   <= '0;
                            end
`endif
                        end
                    end
                    WDATA: begin
                        if (sclk_rise) begin
                            sh  <= sh_next[SH_W-1:0];
                            cnt <= cnt + 1'b1;
`ifdef SLAVE_PORT_PARITY_EN
                            par_acc <= par_bad;
`endif
                            if (cnt == WD_LAST) begin
                                state <= DONE;
`ifdef SLAVE_PORT_PARITY_EN
                                if (!par_bad) begin
                                    write      <= 1'b1;
                                    write_addr <= addr_q;
                                    write_node <= sh_next[DATA_W:1];
                                end else begin
                                    frame_err  <= 1'b1;
                                end
`else
                                write      <= 1'b1;
                                write_addr <= addr_q;
                                write_node <= sh_next;
`endif
                            end
                        end
                    end
                    RWAIT: begin
                        // First cycle lets read_node settle after read_addr.
                        if (cnt == '0) begin
                            cnt <= 1;
                        end else begin
                            cnt   <= '0;
                            state <= RDATA;
`ifdef SLAVE_PORT_PARITY_EN
                            if (rd_bad) begin
                                sdo   <= 1'b0;
                                tx_sh <= '0;
                            end else begin
                                sdo   <= read_node[DATA_W-1];
                                tx_sh <= read_node[DATA_W-2:0];
                            end
`else
                            sdo   <= read_node[DATA_W-1];
                            tx_sh <= read_node[DATA_W-2:0];
`endif
                        end
                    end
                    RDATA: begin
                        // The MSB is already out; the fall ahead of the
                        // first data rise must keep it.
                        if (sclk_fall && cnt != '0) begin
                            sdo   <= tx_sh[DATA_W-2];
                            tx_sh <= {tx_sh[DATA_W-3:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            cnt <= cnt + 1'b1;
                            if (cnt == RD_LAST) begin
                                state <= DONE;
                                sdo   <= 1'b0;
                            end
                        end
                    end
                    DONE: begin
                        if (cs_rise)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_slave_serial_port.sv
// tb_slave_serial_port: directed + random frames against a
// frame-level reference of the node memory and pin protocol.
module tb_slave_serial_port;
    localparam int H = 6;
`ifdef SLAVE_PORT_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs_n = 1'b1;
    logic        sclk = 1'b0;
    logic        sdi = 1'b0;
    logic        sdo, write, frame_err, busy;
    logic [4:0]  write_addr, read_addr;
    logic [11:0] write_node, read_node;

    always #5 clk = ~clk;

    slave_serial_port dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .sclk(sclk),
        .sdi(sdi), .sdo(sdo), .write(write),
        .write_addr(write_addr), .write_node(write_node),
        .read_addr(read_addr), .read_node(read_node),
        .frame_err(frame_err), .busy(busy)
    );

    logic [11:0] mem [32];
    logic [11:0] ref_mem [32];
    logic        mem_load = 1'b0;
    int wr_pulses = 0, wr_run = 0, wr_width = 0;
    int er_pulses = 0, er_run = 0, er_width = 0;
    logic [4:0]  last_wa = '0;
    logic [11:0] last_wn = '0;

    // Node memory model plus strobe monitors.
    always @(posedge clk) begin
        if (mem_load)
            for (int i = 0; i < 32; i++) mem[i] <= ref_mem[i];
        else if (write)
            mem[write_addr] <= write_node;
        read_node <= mem[read_addr];
        if (write) begin
            if (wr_run == 0) wr_pulses <= wr_pulses + 1;
            wr_run  <= wr_run + 1;
            last_wa <= write_addr;
            last_wn <= write_node;
        end else begin
            if (wr_run != 0) wr_width <= wr_run;
            wr_run <= 0;
        end
        if (frame_err) begin
            if (er_run == 0) er_pulses <= er_pulses + 1;
            er_run <= er_run + 1;
        end else begin
            if (er_run != 0) er_width <= er_run;
            er_run <= 0;
        end
    end

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic rw, input logic [4:0] a,
                         input logic [11:0] d, input int stop_after,
                         input logic flip_par, input int extra,
                         output logic [11:0] rx, output logic busy_seen,
                         output logic sdo_any);
        logic bits[$];
        int hdr;
        logic p;
        rx = '0;
        sdo_any = 1'b0;
        bits.push_back(rw);
        for (int i = 4; i >= 0; i--) bits.push_back(a[i]);
        if (rw)
            for (int i = 11; i >= 0; i--) bits.push_back(d[i]);
        p = 1'(($countones(a) + int'(rw) +
                (rw ? $countones(d) : 0)) % 2);
        if (PB == 1) bits.push_back(p ^ flip_par);
        hdr = bits.size();
        if (!rw)
            for (int i = 0; i < 12; i++) bits.push_back(1'($urandom));
        cs_n = 1'b0;
        tick(H);
        for (int i = 0; i < bits.size() && i < stop_after; i++) begin
            sdi = bits[i];
            tick(H);
            if (!rw && i >= hdr) rx = {rx[10:0], sdo};
            sclk = 1'b1;
            tick(H);
            sclk = 1'b0;
        end
        for (int i = 0; i < extra; i++) begin
            sdi = 1'($urandom);
            tick(H);
            sdo_any |= sdo;
            sclk = 1'b1;
            tick(H);
            sclk = 1'b0;
        end
        tick(H);
        busy_seen = busy;
        cs_n = 1'b1;
        tick(2 * H);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [11:0] d,
                            input logic flip, input int extra);
        int w0, e0;
        logic [11:0] rx;
        logic bs, sa;
        w0 = wr_pulses;
        e0 = er_pulses;
        frame(1'b1, a, d, 1000, flip, extra, rx, bs, sa);
        if (!flip) begin
            chk("wr_count", wr_pulses - w0, 1);
            chk("wr_width", wr_width, 1);
            chk("wr_addr_node", {last_wa, last_wn}, {a, d});
            chk("wr_hold", {write_addr, write_node}, {a, d});
            chk("wr_no_err", er_pulses - e0, 0);
            ref_mem[a] = d;
        end else begin
            chk("badpar_no_wr", wr_pulses - w0, 0);
            chk("badpar_err", er_pulses - e0, 1);
        end
        chk("wr_busy", {bs, busy}, 2'b10);
    endtask

    task automatic do_read(input logic [4:0] a, input logic flip,
                           input int extra);
        int w0, e0;
        logic [11:0] rx;
        logic bs, sa;
        w0 = wr_pulses;
        e0 = er_pulses;
        frame(1'b0, a, 12'h0, 1000, flip, extra, rx, bs, sa);
        if (!flip) begin
            chk("rd_addr", read_addr, a);
            chk("rd_data", rx, ref_mem[a]);
            chk("rd_no_err", er_pulses - e0, 0);
        end else begin
            chk("badpar_rd_zero", rx, 0);
            chk("badpar_rd_err", er_pulses - e0, 1);
        end
        chk("rd_busy", {bs, busy}, 2'b10);
        chk("rd_no_wr", wr_pulses - w0, 0);
        if (extra > 0) chk("done_sdo", sa, 1'b0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] rx;
        logic bs, sa;
        int w0, e0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 12'($urandom);
        mem_load = 1'b1;
        tick(3);
        mem_load = 1'b0;
        chk("reset_outs",
            {sdo, write, write_addr, write_node, read_addr, frame_err, busy},
            '0);

        cs_n = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(10);
        chk("cs_low_at_release", busy, 1'b0);
        cs_n = 1'b1;
        tick(10);

        do_write(5'd5, 12'hA5C, 1'b0, 0);
        do_read(5'd5, 1'b0, 0);

        w0 = wr_pulses;
        e0 = er_pulses;
        frame(1'b1, 5'd9, 12'h3C3, 10, 1'b0, 0, rx, bs, sa);
        chk("abort_no_wr", wr_pulses - w0, 0);
        chk("abort_err", er_pulses - e0, 1);
        chk("abort_err_width", er_width, 1);
        chk("abort_idle", busy, 1'b0);
        do_write(5'd0, 12'h001, 1'b0, 0);

        cs_n = 1'b0;
        tick(H);
        for (int i = 0; i < 8; i++) begin
            sdi = (i >= 1 && i <= 5) ? 1'b1 : 1'b0;
            tick(H);
            sclk = 1'b1;
            tick(H);
            if (i < 7) sclk = 1'b0;
        end
        chk("pre_reset_raddr", read_addr, 5'd31);
        reset = 1'b1;
        #1;
        chk("mid_reset_outs",
            {sdo, write, write_addr, write_node, read_addr, frame_err, busy},
            '0);
        tick(3);
        sclk = 1'b0;
        cs_n = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(10);
        do_read(5'd31, 1'b0, 0);

        do_write(5'd31, 12'hFFF, 1'b0, 20);
        do_read(5'd31, 1'b0, 20);

        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(1))
                do_write(5'($urandom), 12'($urandom), 1'b0, 0);
            else
                do_read(5'($urandom), 1'b0, 0);
        end

        if (PB == 1) begin
            do_write(5'd3, 12'h123, 1'b0, 0);
            do_write(5'd3, 12'h456, 1'b1, 0);
            do_read(5'd3, 1'b0, 0);
            do_read(5'd3, 1'b1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
